instr_sequencer: RTL and testbench

//   Control-path sequencer that sits directly upstream of the instruction decoder.
//   It drives the decoder's 2-bit state (FETCH/EXEC1/EXEC2) and latches the

---
 rtl/instr_sequencer.sv | 134 +++++++++++++
 tb/tb_instr_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - FETCH/EXEC1/EXEC2/HALT sequencer feeding the instruction decoder.
// Optional single-step pause is enabled by defining INSTR_SEQUENCER_SINGLE_STEP_EN.
module instr_sequencer #(
  parameter int          CNT_W    = 32,
  parameter logic [15:0] IR_RESET = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      ram_instr_q,
  input  logic             sm_extra,
  input  logic             stop,
  input  logic             set_jump,
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  input  logic             step_mode,
`endif
  output logic [1:0]       state,
  output logic [15:0]      instruction,
  output logic             jump,
  output logic             halted,
  output logic [CNT_W-1:0] retire_count,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [1:0] S_FETCH = 2'b00;
  localparam logic [1:0] S_EXEC1 = 2'b01;
  localparam logic [1:0] S_EXEC2 = 2'b10;
  localparam logic [1:0] S_HALT  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [15:0]      instr_q, instr_d;
  logic             jump_q, jump_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;

  logic retire;
  logic resume;
  logic step_pause;
  logic clear_cnt;

  // An instruction completes when EXEC1 does not continue into EXEC2, or when EXEC2 ends.
  assign retire = ((state_q == S_EXEC1) && (stop || !sm_extra)) || (state_q == S_EXEC2);
  assign resume = (state_q == S_HALT) && start && !stop;

`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  logic paused_q, paused_d;

  assign step_pause = step_mode && retire && !stop;
  assign clear_cnt  = resume && !paused_q;

  always_comb begin
    paused_d = paused_q;
    if (step_pause) paused_d = 1'b1;
    if (resume)     paused_d = 1'b0;
    if (stop)       paused_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) paused_q <= 1'b0;
    else        paused_q <= paused_d;
  end
`else
  assign step_pause = 1'b0;
  assign clear_cnt  = resume;
`endif

  always_comb begin
    state_d = state_q;
    if ((state_q != S_HALT) && stop) begin
      state_d = S_HALT;
    end else begin
      case (state_q)
        S_HALT:  state_d = resume ? S_FETCH : S_HALT;
        S_FETCH: state_d = S_EXEC1;
        S_EXEC1: state_d = sm_extra ? S_EXEC2 : (step_pause ? S_HALT : S_FETCH);
        S_EXEC2: state_d = step_pause ? S_HALT : S_FETCH;
        default: state_d = S_HALT;
      endcase
    end
  end

  always_comb begin
    instr_d = instr_q;
    if ((state_q == S_FETCH) && (state_d == S_EXEC1)) instr_d = ram_instr_q;
  end

  // Set beats the EXEC1 clear; entering HALT beats both.
  always_comb begin
    jump_d = jump_q;
    if ((state_q == S_EXEC1) && !set_jump)    jump_d = 1'b0;
    if (set_jump && (state_q != S_HALT))      jump_d = 1'b1;
    if ((state_d == S_HALT) && (state_q != S_HALT)) jump_d = 1'b0;
  end

  always_comb begin
    retire_d = retire_q;
    cycle_d  = cycle_q;
    if (clear_cnt) begin
      retire_d = '0;
      cycle_d  = '0;
    end else begin
      if (retire && (retire_q != CNT_MAX))                cycle_d  = cycle_q;
      if (retire && (retire_q != CNT_MAX))                retire_d = retire_q + CNT_ONE;
      if ((state_q != S_HALT) && (cycle_q != CNT_MAX))    cycle_d  = cycle_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_HALT;
      instr_q  <= IR_RESET;
      jump_q   <= 1'b0;
      retire_q <= '0;
      cycle_q  <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      jump_q   <= jump_d;
      retire_q <= retire_d;
      cycle_q  <= cycle_d;
    end
  end

  assign state        = state_q;
  assign instruction  = instr_q;
  assign jump         = jump_q;
  assign halted       = (state_q == S_HALT);
  assign retire_count = retire_q;
  assign cycle_count  = cycle_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer.
module tb_instr_sequencer;

  localparam int          CNT_W    = 6;
  localparam logic [15:0] IR_RST   = 16'hBEEF;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [15:0]      ram_instr_q = 16'h0000;
  logic             sm_extra = 1'b0;
  logic             stop = 1'b0;
  logic             set_jump = 1'b0;
  logic             step_mode = 1'b0;
  logic [1:0]       state;
  logic [15:0]      instruction;
  logic             jump;
  logic             halted;
  logic [CNT_W-1:0] retire_count;
  logic [CNT_W-1:0] cycle_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_sequencer #(.CNT_W(CNT_W), .IR_RESET(IR_RST)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .ram_instr_q  (ram_instr_q),
    .sm_extra     (sm_extra),
    .stop         (stop),
    .set_jump     (set_jump),
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    .step_mode    (step_mode),
`endif
    .state        (state),
    .instruction  (instruction),
    .jump         (jump),
    .halted       (halted),
    .retire_count (retire_count),
    .cycle_count  (cycle_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    #1;
    tests++; if (state !== 2'b11) begin fails++; $display("FAIL reset_state got %b want 11", state); end
    tests++; if (instruction !== IR_RST) begin fails++; $display("FAIL reset_ir got %h want %h", instruction, IR_RST); end
    tests++; if (jump !== 1'b0 || halted !== 1'b1) begin fails++; $display("FAIL reset_flags got jump=%b halted=%b want 0 1", jump, halted); end
    tests++; if (retire_count !== '0 || cycle_count !== '0) begin fails++; $display("FAIL reset_cnt got %0d %0d want 0 0", retire_count, cycle_count); end
  endtask

  task automatic test_add();
    start = 1'b1; ram_instr_q = 16'h4000; sm_extra = 1'b0;
    tick();
    start = 1'b0;
    tests++; if (state !== 2'b00 || halted !== 1'b0) begin fails++; $display("FAIL add_fetch got %b halted=%b want 00 0", state, halted); end
    tick();
    tests++; if (state !== 2'b01 || instruction !== 16'h4000) begin fails++; $display("FAIL add_exec1 got %b %h want 01 4000", state, instruction); end
    tests++; if (retire_count !== 6'd0 || cycle_count !== 6'd1) begin fails++; $display("FAIL add_cnt_exec1 got %0d %0d want 0 1", retire_count, cycle_count); end
    tick();
    tests++; if (state !== 2'b00 || retire_count !== 6'd1 || cycle_count !== 6'd2) begin fails++; $display("FAIL add_retire got %b %0d %0d want 00 1 2", state, retire_count, cycle_count); end
  endtask

  task automatic test_ldi();
    ram_instr_q = 16'h0500; sm_extra = 1'b1;
    tick();
    tests++; if (state !== 2'b01 || instruction !== 16'h0500 || retire_count !== 6'd1) begin fails++; $display("FAIL ldi_exec1 got %b %h %0d want 01 0500 1", state, instruction, retire_count); end
    ram_instr_q = 16'h1234;
    tick();
    sm_extra = 1'b0;
    tests++; if (state !== 2'b10 || instruction !== 16'h0500 || retire_count !== 6'd1) begin fails++; $display("FAIL ldi_exec2 got %b %h %0d want 10 0500 1", state, instruction, retire_count); end
    tick();
    tests++; if (state !== 2'b00 || retire_count !== 6'd2 || cycle_count !== 6'd5) begin fails++; $display("FAIL ldi_retire got %b %0d %0d want 00 2 5", state, retire_count, cycle_count); end
  endtask

  task automatic test_jump();
    ram_instr_q = 16'h8000;
    tick();
    set_jump = 1'b1;
    tick();
    set_jump = 1'b0;
    tests++; if (state !== 2'b00 || jump !== 1'b1) begin fails++; $display("FAIL jump_set got %b %b want 00 1", state, jump); end
    tick();
    tests++; if (state !== 2'b01 || jump !== 1'b1) begin fails++; $display("FAIL jump_hold got %b %b want 01 1", state, jump); end
    tick();
    tests++; if (jump !== 1'b0) begin fails++; $display("FAIL jump_clear got %b want 0", jump); end
    tick();
    set_jump = 1'b1;
    tick();
    tick();
    tests++; if (state !== 2'b01 || jump !== 1'b1) begin fails++; $display("FAIL jump_reset2 got %b %b want 01 1", state, jump); end
    tick();
    set_jump = 1'b0;
    tests++; if (state !== 2'b00 || jump !== 1'b1 || retire_count !== 6'd6) begin fails++; $display("FAIL jump_setwins got %b %b %0d want 00 1 6", state, jump, retire_count); end
  endtask

  task automatic test_stop();
    tick();
    stop = 1'b1;
    tick();
    tests++; if (state !== 2'b11 || jump !== 1'b0 || halted !== 1'b1) begin fails++; $display("FAIL stop_halt got %b jump=%b halted=%b want 11 0 1", state, jump, halted); end
    tests++; if (retire_count !== 6'd7 || cycle_count !== 6'd15) begin fails++; $display("FAIL stop_cnt got %0d %0d want 7 15", retire_count, cycle_count); end
    start = 1'b1;
    tick();
    tests++; if (state !== 2'b11 || cycle_count !== 6'd15) begin fails++; $display("FAIL stop_start got %b %0d want 11 15", state, cycle_count); end
    stop = 1'b0;
    tick();
    start = 1'b0;
    tests++; if (state !== 2'b00 || retire_count !== '0 || cycle_count !== '0) begin fails++; $display("FAIL start_clear got %b %0d %0d want 00 0 0", state, retire_count, cycle_count); end
  endtask

  task automatic test_async_reset();
    ram_instr_q = 16'h0500; sm_extra = 1'b1;
    tick();
    tick();
    sm_extra = 1'b0;
    tests++; if (state !== 2'b10) begin fails++; $display("FAIL areset_pre got %b want 10", state); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (state !== 2'b11 || instruction !== IR_RST || retire_count !== '0 || cycle_count !== '0 || jump !== 1'b0) begin fails++; $display("FAIL areset got %b %h %0d %0d %b want 11 %h 0 0 0", state, instruction, retire_count, cycle_count, jump, IR_RST); end
    #3 rst_n = 1'b1;
  endtask

  task automatic test_saturate();
    ram_instr_q = 16'h4000; sm_extra = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 140; i++) tick();
    tests++; if (cycle_count !== CMAX || retire_count !== CMAX) begin fails++; $display("FAIL saturate got %0d %0d want %0d %0d", cycle_count, retire_count, CMAX, CMAX); end
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    tests++; if (cycle_count !== CMAX || halted !== 1'b0) begin fails++; $display("FAIL start_ignored got %0d halted=%b want %0d 0", cycle_count, halted, CMAX); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tests++; if (state !== 2'b11) begin fails++; $display("FAIL sat_stop got %b want 11", state); end
  endtask

`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  task automatic test_single_step();
    step_mode = 1'b1; ram_instr_q = 16'h4000; sm_extra = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tests++; if (state !== 2'b11 || retire_count !== n[CNT_W-1:0] || cycle_count !== 6'(2 * n)) begin fails++; $display("FAIL step_%0d got %b %0d %0d want 11 %0d %0d", n, state, retire_count, cycle_count, n, 2 * n); end
    end
    step_mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_ldi();
    test_jump();
    test_stop();
    test_async_reset();
    test_saturate();
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
